// File: rtl/color_normalizer_pkg.sv
// Shared types and helpers for the RGB sample normalizer.
// Holds the FSM state encoding, the latched-sample record and a three-way max.
package color_normalizer_pkg;

   localparam int IN_W      = 16;
   localparam int OUT_W     = 8;
   localparam int DIV_STEPS = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAX,
      S_DIV_R,
      S_DIV_G,
      S_DIV_B,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [IN_W-1:0] r;
      logic [IN_W-1:0] g;
      logic [IN_W-1:0] b;
   } rgb_raw_t;

   function automatic logic [IN_W-1:0] max3(input logic [IN_W-1:0] a,
                                            input logic [IN_W-1:0] b,
                                            input logic [IN_W-1:0] c);
      logic [IN_W-1:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/frac_div8.sv
// Serial restoring divider producing floor(num*256/den), one quotient bit per cycle.
// A start may coincide with the final step; the final quotient is presented on q while q_valid is high.
module frac_div8
   import color_normalizer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IN_W-1:0]  num,
   input  logic [IN_W-1:0]  den,
   output logic [OUT_W-1:0] q,
   output logic             q_valid
);

   logic [IN_W:0]    rem;
   logic [IN_W:0]    shifted;
   logic [IN_W-1:0]  den_q;
   logic [OUT_W-2:0] q_acc;
   logic [2:0]       cnt;
   logic             active;
   logic             sat;
   logic             q_bit;

   // NOTE: combinational blocks assign every output up front so no latch can be inferred.
   always_comb begin
      shifted = rem << 1;
      q_bit   = (shifted >= {1'b0, den_q});
      q_valid = active && (cnt == 3'd0);
      q       = sat ? {OUT_W{1'b1}} : {q_acc, q_bit};
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem    <= '0;
         den_q  <= '0;
         q_acc  <= '0;
         cnt    <= '0;
         active <= 1'b0;
         sat    <= 1'b0;
      end else if (start) begin
         rem    <= {1'b0, num};
         den_q  <= den;
         q_acc  <= '0;
         cnt    <= 3'(DIV_STEPS - 1);
         active <= 1'b1;
         sat    <= (num == den);
      end else if (active) begin
         rem    <= q_bit ? (shifted - {1'b0, den_q}) : shifted;
         q_acc  <= {q_acc[OUT_W-3:0], q_bit};
         cnt    <= cnt - 3'd1;
         if (cnt == 3'd0) active <= 1'b0;
      end
   end

endmodule

// File: rtl/color_normalizer.sv
// Captures one 16-bit RGB sample on a data_ready rising edge and scales it so the
// brightest channel reads 255, reusing one serial divider for R, G and B in turn.
module color_normalizer
   import color_normalizer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             data_ready,
   input  logic [IN_W-1:0]  red_i,
   input  logic [IN_W-1:0]  green_i,
   input  logic [IN_W-1:0]  blue_i,
   input  logic             bypass,
   output logic [OUT_W-1:0] red,
   output logic [OUT_W-1:0] green,
   output logic [OUT_W-1:0] blue,
   output logic             busy,
   output logic             done
);

   state_t           state;
   state_t           next_state;
   rgb_raw_t         raw;
   logic             byp_q;
   logic             rdy_q;
   logic [IN_W-1:0]  max_val;
   logic [IN_W-1:0]  div_num;
   logic             div_start;
   logic             capture;
   logic [OUT_W-1:0] div_q;
   logic             div_valid;
   logic [OUT_W-1:0] stage_r;
   logic [OUT_W-1:0] stage_g;
   logic [OUT_W-1:0] stage_b;

   assign max_val = max3(raw.r, raw.g, raw.b);
   assign busy    = (state != S_IDLE);

   frac_div8 u_div (
      .clk     (clk),
      .rst     (rst),
      .start   (div_start),
      .num     (div_num),
      .den     (max_val),
      .q       (div_q),
      .q_valid (div_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      div_start  = 1'b0;
      div_num    = raw.r;
      case (state)
         S_IDLE: begin
            if (data_ready && !rdy_q) begin
               capture    = 1'b1;
               next_state = S_MAX;
            end
         end
         S_MAX: begin
            if (byp_q || (max_val == '0)) begin
               next_state = S_DONE;
            end else begin
               div_start  = 1'b1;
               next_state = S_DIV_R;
            end
         end
         // Each channel hands over on its last step so the next division starts without a gap.
         S_DIV_R: begin
            div_num = raw.g;
            if (div_valid) begin
               div_start  = 1'b1;
               next_state = S_DIV_G;
            end
         end
         S_DIV_G: begin
            div_num = raw.b;
            if (div_valid) begin
               div_start  = 1'b1;
               next_state = S_DIV_B;
            end
         end
         S_DIV_B: begin
            if (div_valid) next_state = S_DONE;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // rdy_q resets high so a level already present at reset release is not taken as an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_q   <= 1'b1;
         raw     <= '0;
         byp_q   <= 1'b0;
         stage_r <= '0;
         stage_g <= '0;
         stage_b <= '0;
         red     <= '0;
         green   <= '0;
         blue    <= '0;
         done    <= 1'b0;
      end else begin
         rdy_q <= data_ready;
         done  <= (state == S_DONE);
         if (capture) begin
            raw   <= '{r: red_i, g: green_i, b: blue_i};
            byp_q <= bypass;
         end
         if (state == S_MAX) begin
            stage_r <= byp_q ? raw.r[IN_W-1 -: OUT_W] : '0;
            stage_g <= byp_q ? raw.g[IN_W-1 -: OUT_W] : '0;
            stage_b <= byp_q ? raw.b[IN_W-1 -: OUT_W] : '0;
         end
         if (div_valid) begin
            if (state == S_DIV_R) stage_r <= div_q;
            if (state == S_DIV_G) stage_g <= div_q;
            if (state == S_DIV_B) stage_b <= div_q;
         end
         if (state == S_DONE) begin
            red   <= stage_r;
            green <= stage_g;
            blue  <= stage_b;
         end
      end
   end

endmodule

// File: tb/tb_color_normalizer.sv
// Self-checking bench for color_normalizer: directed corner cases plus random samples
// compared against an arithmetic model of the normalization.
module tb_color_normalizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        data_ready;
   logic [15:0] red_i, green_i, blue_i;
   logic        bypass;
   logic [7:0]  red, green, blue;
   logic        busy, done;

   int tests = 0;
   int fails = 0;
   logic [7:0] held_r, held_g, held_b;

   always #5 clk = ~clk;

   color_normalizer dut (
      .clk        (clk),
      .rst        (rst),
      .data_ready (data_ready),
      .red_i      (red_i),
      .green_i    (green_i),
      .blue_i     (blue_i),
      .bypass     (bypass),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] model(input int unsigned c, input int unsigned m, input logic byp);
      if (byp)    return 8'(c >> 8);
      if (m == 0) return 8'd0;
      if (c == m) return 8'd255;
      return 8'((c * 256) / m);
   endfunction

   function automatic int unsigned max_of(input int unsigned a, input int unsigned b, input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Drives one sample with a clean rising edge and checks latency, busy, done and results.
   task automatic run_sample(input string tag, input logic [15:0] r, input logic [15:0] g,
                             input logic [15:0] b, input logic byp);
      int unsigned m;
      int lat;
      int cnt;
      logic [7:0] er, eg, eb;
      m   = max_of(r, g, b);
      er  = model(r, m, byp);
      eg  = model(g, m, byp);
      eb  = model(b, m, byp);
      lat = (byp || m == 0) ? 2 : 26;
      @(negedge clk);
      data_ready = 1'b0;
      @(negedge clk);
      red_i = r; green_i = g; blue_i = b; bypass = byp;
      data_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      red_i = 16'($urandom); green_i = 16'($urandom); blue_i = 16'($urandom); bypass = ~byp;
      check({tag, " busy_at_t0"}, {31'd0, busy}, 32'd1);
      check({tag, " held_out"}, {8'd0, red, green, blue}, {8'd0, held_r, held_g, held_b});
      cnt = 0;
      while (!done && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check({tag, " latency"}, cnt, lat);
      check({tag, " red"}, {24'd0, red}, {24'd0, er});
      check({tag, " green"}, {24'd0, green}, {24'd0, eg});
      check({tag, " blue"}, {24'd0, blue}, {24'd0, eb});
      check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
      held_r = er; held_g = eg; held_b = eb;
      @(negedge clk);
      check({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
      data_ready = 1'b0;
   endtask

   initial begin
      int bad;
      int n;
      int mode;
      logic [15:0] r, g, b;
      logic byp;

      rst = 1'b1; data_ready = 1'b1; bypass = 1'b0;
      red_i = 16'hFFFF; green_i = 16'hFFFF; blue_i = 16'hFFFF;
      held_r = 8'd0; held_g = 8'd0; held_b = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (busy || done || red != 0 || green != 0 || blue != 0) bad++;
      end
      check("reset_level_no_capture", bad, 0);

      run_sample("scale_pow2", 16'h8000, 16'h4000, 16'h2000, 1'b0);
      run_sample("small_thirds", 16'd1, 16'd3, 16'd0, 1'b0);
      run_sample("all_zero", 16'd0, 16'd0, 16'd0, 1'b0);
      run_sample("bypass", 16'hABCD, 16'h1234, 16'hFF00, 1'b1);
      run_sample("max_full", 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);

      // Second rising edge during busy must be ignored.
      @(negedge clk);
      data_ready = 1'b0;
      @(negedge clk);
      red_i = 16'h0100; green_i = 16'h0200; blue_i = 16'h0400; bypass = 1'b0;
      data_ready = 1'b1;
      @(posedge clk);
      repeat (5) @(negedge clk);
      data_ready = 1'b0;
      repeat (5) @(negedge clk);
      red_i = 16'h0400; green_i = 16'h0001; blue_i = 16'h0000; bypass = 1'b1;
      data_ready = 1'b1;
      n = 10;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ignore latency", n - 1, 26);
      check("ignore red", {24'd0, red}, 32'd64);
      check("ignore green", {24'd0, green}, 32'd128);
      check("ignore blue", {24'd0, blue}, 32'd255);
      held_r = 8'd64; held_g = 8'd128; held_b = 8'd255;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) bad++;
      end
      check("ignore no_second_done", bad, 0);

      // Reset at t0+15 aborts the operation.
      @(negedge clk);
      data_ready = 1'b0;
      @(negedge clk);
      red_i = 16'h1000; green_i = 16'h0800; blue_i = 16'h0400; bypass = 1'b0;
      data_ready = 1'b1;
      @(posedge clk);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort outputs", {8'd0, red, green, blue}, 32'd0);
      check("abort busy_done", {30'd0, busy, done}, 32'd0);
      rst = 1'b0;
      held_r = 8'd0; held_g = 8'd0; held_b = 8'd0;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (done || busy) bad++;
      end
      check("abort no_done", bad, 0);
      run_sample("after_abort", 16'h1000, 16'h0800, 16'h0400, 1'b0);

      for (int i = 0; i < 16; i++) begin
         mode = int'($urandom_range(0, 5));
         r = 16'($urandom); g = 16'($urandom); b = 16'($urandom);
         byp = 1'b0;
         case (mode)
            0: byp = 1'b1;
            1: begin r = 16'd0; g = 16'd0; b = 16'd0; end
            2: begin r = 16'($urandom_range(0, 7)); g = 16'($urandom_range(0, 7)); b = 16'($urandom_range(1, 7)); end
            3: begin g = r; b = 16'($urandom_range(0, 3)); end
            default: ;
         endcase
         run_sample($sformatf("rand%0d", i), r, g, b, byp);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
